cond_unit: RTL and testbench
============================

// Module: cond_unit
// PURPOSE
//  Consumer end of the ALU flag interface: holds the architectural NZCV register, evaluates
//  each instruction's 4-bit ARM condition field against it, and commits ALU/shifter flags.
//  One-entry EX stage with valid/ready on both sides, between decode and writeback.
//  flags[1] (C) feeds the ALU carry input for ADC/SBC/RSC.
// PARAMETERS
//  CNT_W   32   width of the saturating skipped-instruction counter
// PORTS
//  clk            in   1      clock; all state updates on the rising edge
//  reset          in   1      synchronous, active-low reset
//  in_valid       in   1      decode offers an instruction
//  in_ready       out  1      EX stage can accept
//  in_cond        in   4      ARM condition field
//  in_opcode      in   4      ALU opcode (shared encoding, alu_pkg)
//  in_s           in   1      S bit: instruction requests a flag update
//  alu_flags      in   4      {N,Z,C,V} from the ALU, for the instruction currently in EX
//  shift_carry    in   1      barrel-shifter carry-out for the instruction in EX
//  flags_wr_en    in   1      direct NZCV write (MSR-style)
//  flags_wr_data  in   4      {N,Z,C,V} written when flags_wr_en=1
//  out_valid      out  1      EX holds an instruction
//  out_ready      in   1      writeback accepts
//  out_pass       out  1      condition passed: writeback may commit the result
//  out_opcode     out  4      opcode of the EX instruction
//  flags          out  4      current NZCV register {N,Z,C,V}
//  skip_count     out  CNT_W  instructions retired with out_pass=0
//  undef          out  1      one-cycle pulse on NV retirement (COND_NV_UNDEF_EN only)
// BEHAVIOUR
//  - Reset (reset==0 at edge): ex_valid=0, flags=4'h0, skip_count=0, undef=0; inputs ignored.
//  - in_ready = !ex_valid | out_ready. Accept on in_valid & in_ready: latch cond/opcode/s into EX.
//  - out_valid = ex_valid. Retire on out_valid & out_ready. Accept and retire in the same cycle
//    is allowed (full throughput, 1-cycle latency). No accept in that cycle -> ex_valid clears.
//  - out_pass is combinational from the EX cond and the flags register:
//    EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V,
//    LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, NV 0.
//  - Flag commit happens only at retire, and only when out_pass=1 and (s=1 or opcode in 8..B).
//    Opcodes 8..B (TST/TEQ/CMP/CMN) always set flags, whatever s is.
//    Arithmetic (2..7, A, B): flags <= alu_flags.
//    Logical (0, 1, 8, 9, C, D, E, F): N,Z <= alu_flags; C <= shift_carry; V is held.
//  - flags_wr_en has priority over a same-cycle ALU commit: flags <= flags_wr_data.
//  - out_ready=0 stall: EX contents, out_* and flags are held; only flags_wr_en changes flags,
//    and out_pass re-evaluates against the new value.
//  - skip_count +1 on each retire with out_pass=0; saturates at all-ones (no wrap).
//  - Mid-operation reset drops the EX instruction without commit; no partial flag update.
// CONFIGURATION
//  COND_NV_UNDEF_EN defined: cond=4'hF retires with out_pass=0, undef=1 for that one cycle,
//    and it is NOT counted in skip_count.
//  Not defined: NV is an ordinary never-condition (pass=0, counted); undef tied to 0.
// STRUCTURE
//  alu_pkg: opcode constants (AND..MVN), flag bit indices NEG=3/ZER=2/CAR=1/OVR=0,
//    cond_e enum (EQ..NV), is_logical()/is_compare() functions.
//  Sub-module cond_eval (combinational: cond, nzcv -> pass); EX register and counter stay in cond_unit.
// TESTING
//  1 reset low 2 cycles -> flags=0, out_valid=0, skip_count=0, in_ready=1, undef=0.
//  2 CMP (op A, s=0, AL), alu_flags=4'b0110, retire -> flags=0110; then EQ -> pass=1; NE -> pass=0, skip_count=1.
//  3 flags=0001; ANDS (op 0, s=1), alu_flags=1000, shift_carry=1 -> flags=1011 (V kept).
//  4 out_ready=0 for 3 cycles with EX full -> in_ready=0, out_* stable, flags unchanged; release -> exactly one commit.
//  5 flags=1000: GE pass=0, LT pass=1; ADDS retire with flags_wr_en=1, data=0100 -> flags=0100.
//  6 cond=F: macro on -> undef 1-cycle pulse, skip_count unchanged; macro off -> undef=0, skip_count+1.
//  7 back-to-back: ADDS (alu_flags=0100) then EQ in consecutive cycles -> EQ sees Z=1, pass=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, NZCV bit positions, ARM condition codes and
// opcode classification helpers.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam int unsigned NEG = 3;
    localparam int unsigned ZER = 2;
    localparam int unsigned CAR = 1;
    localparam int unsigned OVR = 0;

    typedef enum logic [3:0] {
        CondEq, CondNe, CondCs, CondCc, CondMi, CondPl, CondVs, CondVc,
        CondHi, CondLs, CondGe, CondLt, CondGt, CondLe, CondAl, CondNv
    } cond_e;

    // Logical ops take C from the shifter and leave V untouched.
    function automatic logic is_logical(input logic [3:0] op);
        return (op <= OP_EOR) || (op == OP_TST) || (op == OP_TEQ) || (op >= OP_ORR);
    endfunction

    function automatic logic is_compare(input logic [3:0] op);
        return (op >= OP_TST) && (op <= OP_CMN);
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator: cond field against NZCV.
module cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    always_comb begin
        n    = nzcv[NEG];
        z    = nzcv[ZER];
        c    = nzcv[CAR];
        v    = nzcv[OVR];
        pass = 1'b0;
        case (cond_e'(cond))
            CondEq:  pass = z;
            CondNe:  pass = !z;
            CondCs:  pass = c;
            CondCc:  pass = !c;
            CondMi:  pass = n;
            CondPl:  pass = !n;
            CondVs:  pass = v;
            CondVc:  pass = !v;
            CondHi:  pass = c && !z;
            CondLs:  pass = !c || z;
            CondGe:  pass = (n == v);
            CondLt:  pass = (n != v);
            CondGt:  pass = !z && (n == v);
            CondLe:  pass = z || (n != v);
            CondAl:  pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// One-entry EX stage holding the NZCV register; evaluates conditions and commits flags at retire.
// Optional COND_NV_UNDEF_EN: NV retirement raises undef and is excluded from skip_count.
module cond_unit
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_cond,
    input  logic [3:0]       in_opcode,
    input  logic             in_s,
    input  logic [3:0]       alu_flags,
    input  logic             shift_carry,
    input  logic             flags_wr_en,
    input  logic [3:0]       flags_wr_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_pass,
    output logic [3:0]       out_opcode,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] skip_count,
    output logic             undef
);

    logic             ex_valid_q;
    logic [3:0]       ex_cond_q;
    logic [3:0]       ex_op_q;
    logic             ex_s_q;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] skip_q;
    logic             pass;
    logic             accept, retire, commit, is_nv;

    cond_eval u_cond_eval (
        .cond (ex_cond_q),
        .nzcv (flags_q),
        .pass (pass)
    );

    assign in_ready   = !ex_valid_q || out_ready;
    assign out_valid  = ex_valid_q;
    assign out_pass   = pass;
    assign out_opcode = ex_op_q;
    assign flags      = flags_q;
    assign skip_count = skip_q;
    assign accept     = in_valid && in_ready;
    assign retire     = ex_valid_q && out_ready;
    assign commit     = retire && pass && (ex_s_q || is_compare(ex_op_q));

`ifdef COND_NV_UNDEF_EN
    assign is_nv = (ex_cond_q == CondNv);
    assign undef = retire && is_nv;
`else
    assign is_nv = 1'b0;
    assign undef = 1'b0;
`endif

    always_comb begin
        flags_d = flags_q;
        if (commit) begin
            if (is_logical(ex_op_q)) begin
                flags_d = {alu_flags[NEG], alu_flags[ZER], shift_carry, flags_q[OVR]};
            end else begin
                flags_d = alu_flags;
            end
        end
        // Direct writes override any same-cycle ALU commit.
        if (flags_wr_en) begin
            flags_d = flags_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid_q <= 1'b0;
            ex_cond_q  <= 4'h0;
            ex_op_q    <= 4'h0;
            ex_s_q     <= 1'b0;
            flags_q    <= 4'h0;
            skip_q     <= '0;
        end else begin
            if (accept) begin
                ex_valid_q <= 1'b1;
                ex_cond_q  <= in_cond;
                ex_op_q    <= in_opcode;
                ex_s_q     <= in_s;
            end else if (retire) begin
                ex_valid_q <= 1'b0;
            end
            flags_q <= flags_d;
            if (retire && !pass && !is_nv && (skip_q != '1)) begin
                skip_q <= skip_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: stimulus pushes expected retirements, a monitor pops and checks.
module tb_cond_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cond;
    logic [3:0]  in_opcode;
    logic        in_s;
    logic [3:0]  alu_flags;
    logic        shift_carry;
    logic        flags_wr_en;
    logic [3:0]  flags_wr_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_pass;
    logic [3:0]  out_opcode;
    logic [3:0]  flags;
    logic [31:0] skip_count;
    logic        undef;

    typedef struct packed {
        logic       pass;
        logic [3:0] op;
        logic       undef;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef COND_NV_UNDEF_EN
    localparam logic NV_UNDEF = 1'b1;
`else
    localparam logic NV_UNDEF = 1'b0;
`endif

    always #5 clk = ~clk;

    cond_unit #(.CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_cond       (in_cond),
        .in_opcode     (in_opcode),
        .in_s          (in_s),
        .alu_flags     (alu_flags),
        .shift_carry   (shift_carry),
        .flags_wr_en   (flags_wr_en),
        .flags_wr_data (flags_wr_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pass      (out_pass),
        .out_opcode    (out_opcode),
        .flags         (flags),
        .skip_count    (skip_count),
        .undef         (undef)
    );

    // Monitor: every retirement is matched against the scoreboard.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL retire_unexpected: op=%h pass=%b with empty scoreboard",
                         out_opcode, out_pass);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_pass !== e.pass || out_opcode !== e.op || undef !== e.undef) begin
                    errors++;
                    $display("FAIL retire: got pass=%b op=%h undef=%b, want pass=%b op=%h undef=%b",
                             out_pass, out_opcode, undef, e.pass, e.op, e.undef);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one instruction and return #1 after the accepting edge.
    task automatic send(input logic [3:0] c, input logic [3:0] op, input logic s,
                        input logic p, input logic u);
        bit ok = 0;
        in_valid  = 1'b1;
        in_cond   = c;
        in_opcode = op;
        in_s      = s;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b want 1", in_ready);
        end else begin
            exp_q.push_back('{pass: p, op: op, undef: u});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wr_flags(input logic [3:0] d);
        flags_wr_en   = 1'b1;
        flags_wr_data = d;
        @(posedge clk);
        #1;
        flags_wr_en = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        in_valid      = 1'b0;
        in_cond       = 4'hE;
        in_opcode     = 4'h0;
        in_s          = 1'b0;
        alu_flags     = 4'h0;
        shift_carry   = 1'b0;
        flags_wr_en   = 1'b0;
        flags_wr_data = 4'h0;
        out_ready     = 1'b1;

        // 1: reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_skip", skip_count, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_undef", 32'(undef), 32'h0);
        reset = 1'b1;

        // 2: CMP with s=0 still sets flags; EQ/NE evaluate against them
        alu_flags = 4'b0110;
        send(4'hE, 4'hA, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("cmp_flags", 32'(flags), 32'h6);
        send(4'h0, 4'hD, 1'b0, 1'b1, 1'b0);
        send(4'h1, 4'hD, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("ne_skip", skip_count, 32'h1);

        // 3: logical ANDS keeps V, takes C from the shifter
        wr_flags(4'b0001);
        chk("wr_flags", 32'(flags), 32'h1);
        alu_flags   = 4'b1000;
        shift_carry = 1'b1;
        send(4'hE, 4'h0, 1'b1, 1'b1, 1'b0);
        idle(1);
        chk("ands_flags", 32'(flags), 32'hB);

        // 4: stall with EX full, then exactly one commit
        out_ready = 1'b0;
        alu_flags = 4'b0010;
        send(4'hE, 4'h4, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'h0);
            chk("stall_out", {out_valid, out_pass, out_opcode}, 32'h34);
            chk("stall_flags", 32'(flags), 32'hB);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(1);
        chk("release_flags", 32'(flags), 32'h2);
        alu_flags = 4'b0101;
        idle(2);
        chk("one_commit", 32'(flags), 32'h2);

        // 5: GE/LT with N!=V, then direct write beats ALU commit
        wr_flags(4'b1000);
        send(4'hA, 4'hD, 1'b0, 1'b0, 1'b0);
        send(4'hB, 4'hD, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("ge_skip", skip_count, 32'h2);
        alu_flags = 4'b0010;
        send(4'hE, 4'h4, 1'b1, 1'b1, 1'b0);
        wr_flags(4'b0100);
        chk("wr_priority", 32'(flags), 32'h4);

        // 6: NV
        send(4'hF, 4'hD, 1'b0, 1'b0, NV_UNDEF);
        idle(1);
        chk("nv_skip", skip_count, NV_UNDEF ? 32'h2 : 32'h3);
        chk("nv_undef_low", 32'(undef), 32'h0);

        // 7: back-to-back flag forwarding through the register
        wr_flags(4'b0000);
        alu_flags = 4'b0100;
        send(4'hE, 4'h4, 1'b1, 1'b1, 1'b0);
        send(4'h0, 4'hD, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("b2b_flags", 32'(flags), 32'h4);
        chk("b2b_skip", skip_count, NV_UNDEF ? 32'h2 : 32'h3);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
